// File: rtl/led_flick_sequencer.sv
// led_flick_sequencer: flick-triggered LED fill sequencer (UP1 -> DN1 -> UP2 -> DN2) with
// checkpoint kickback, tick-paced level steps and a registered thermometer LED mask.
module led_flick_sequencer #(
    parameter int N_LED    = 16,
    parameter int TICK_DIV = 1,
    parameter int CP_LO    = 5,
    parameter int CP_HI    = 10
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             flick,
    output logic [N_LED-1:0] LED,
    output logic [2:0]       current_state,
    output logic [4:0]       current_index,
    output logic             step,
    output logic             busy
);
    localparam int TW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

    typedef enum logic [2:0] {IDLE = 3'd0, UP1 = 3'd1, DN1 = 3'd2, UP2 = 3'd3, DN2 = 3'd4} state_t;

    state_t            state_q, state_d, nxt;
    logic [4:0]        level_q, level_d, target;
    logic [TW-1:0]     tick_cnt_q, tick_cnt_d;
    logic [N_LED-1:0]  led_q, led_d;
    logic              flick_q, pend_q, pend_d, step_q, step_d;
    logic              fe, tick, dn, kick;

    assign fe     = flick & ~flick_q;
    assign tick   = tick_cnt_q == TW'(TICK_DIV - 1);
    assign dn     = (state_q == DN1) || (state_q == DN2);
    assign target = (state_q == UP1) ? 5'(N_LED) : (state_q == DN1) ? 5'(CP_LO) :
                    (state_q == UP2) ? 5'(CP_HI) : 5'd0;
    assign nxt    = (state_q == UP1) ? DN1 : (state_q == DN1) ? UP2 : (state_q == UP2) ? DN2 : IDLE;
    // Kickback only fires at the checkpoints reachable while descending in the current DN phase.
    assign kick   = pend_q && (((state_q == DN1) && (level_q == 5'(CP_HI) || level_q == 5'(CP_LO))) ||
                               ((state_q == DN2) && (level_q == 5'(CP_LO) || level_q == 5'd0)));

    always_comb begin
        state_d    = state_q;
        level_d    = level_q;
        pend_d     = pend_q;
        tick_cnt_d = tick ? '0 : tick_cnt_q + 1'b1;
        if (state_q == IDLE) begin
            tick_cnt_d = '0;
            if (fe) state_d = UP1;
        end else begin
            if (fe && dn) pend_d = 1'b1;
            if (tick) begin
                if (kick) begin
                    state_d = (state_q == DN1) ? UP1 : UP2;
                    pend_d  = 1'b0;
                end else if (level_q == target) begin
                    state_d = nxt;
                end else begin
                    level_d = dn ? level_q - 1'b1 : level_q + 1'b1;
                end
            end
        end
        if (state_d != state_q) begin
            tick_cnt_d = '0;
            pend_d     = 1'b0;
        end
        step_d = level_d != level_q;
        for (int i = 0; i < N_LED; i++) led_d[i] = 5'(i) < level_d;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= IDLE;
            level_q    <= '0;
            tick_cnt_q <= '0;
            led_q      <= '0;
            flick_q    <= 1'b0;
            pend_q     <= 1'b0;
            step_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            level_q    <= level_d;
            tick_cnt_q <= tick_cnt_d;
            led_q      <= led_d;
            flick_q    <= flick;
            pend_q     <= pend_d;
            step_q     <= step_d;
        end
    end

    assign LED           = led_q;
    assign current_state = state_q;
    assign current_index = level_q;
    assign step          = step_q;
    assign busy          = state_q != IDLE;
endmodule

// File: tb/tb_led_flick_sequencer.sv
// tb_led_flick_sequencer: directed checks of the flick sequencer, TICK_DIV=1 and TICK_DIV=4 instances.
module tb_led_flick_sequencer;
    logic        clk = 1'b0;
    logic        reset, flick, flick4;
    logic [15:0] led, led4;
    logic [2:0]  st, st4;
    logic [4:0]  idx, idx4;
    logic        step, step4, busy, busy4;
    int          n_cmp = 0;
    int          n_bad = 0;

    always #5 clk = ~clk;

    led_flick_sequencer #(.TICK_DIV(1)) dut (
        .clk(clk), .reset(reset), .flick(flick), .LED(led), .current_state(st),
        .current_index(idx), .step(step), .busy(busy));

    led_flick_sequencer #(.TICK_DIV(4)) dut4 (
        .clk(clk), .reset(reset), .flick(flick4), .LED(led4), .current_state(st4),
        .current_index(idx4), .step(step4), .busy(busy4));

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic go(input int n);
        for (int i = 0; i < n; i++) cyc();
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic pulse();
        flick = 1'b1;
        cyc();
        flick = 1'b0;
    endtask

    initial begin
        logic [16:0] m;
        reset = 1'b1; flick = 1'b0; flick4 = 1'b0;
        go(2);
        chk("rst_state", st, 0);
        chk("rst_led", led, 0);
        chk("rst_idx", idx, 0);
        chk("rst_step", step, 0);
        chk("rst_busy", busy, 0);
        reset = 1'b0;
        cyc();
        // full uninterrupted run
        pulse();
        chk("t1_up1", st, 1);
        chk("t1_led0", led, 0);
        chk("t1_busy", busy, 1);
        for (int i = 1; i <= 16; i++) begin
            cyc();
            m = (17'd1 << i) - 17'd1;
            chk("t1_up_led", led, 32'(m[15:0]));
            chk("t1_up_step", step, 1);
        end
        cyc();
        chk("t1_dn1", st, 2);
        chk("t1_dn1_step", step, 0);
        go(11);
        chk("t1_dn1_led", led, 32'h001F);
        cyc();
        chk("t1_up2", st, 3);
        go(5);
        chk("t1_up2_led", led, 32'h03FF);
        cyc();
        chk("t1_dn2", st, 4);
        go(10);
        chk("t1_dn2_led", led, 0);
        chk("t1_dn2_st", st, 4);
        cyc();
        chk("t1_idle", st, 0);
        chk("t1_idle_busy", busy, 0);
        // kickback in DN1 at level 10
        pulse();
        go(17);
        chk("t2_dn1", st, 2);
        go(3);
        chk("t2_lvl13", idx, 13);
        flick = 1'b1;
        cyc();
        flick = 1'b0;
        go(2);
        chk("t2_lvl10", led, 32'h03FF);
        chk("t2_st_dn1", st, 2);
        cyc();
        chk("t2_kick_st", st, 1);
        chk("t2_kick_led", led, 32'h03FF);
        chk("t2_kick_step", step, 0);
        cyc();
        chk("t2_climb", led, 32'h07FF);
        chk("t2_climb_step", step, 1);
        go(5);
        chk("t2_top", led, 32'hFFFF);
        cyc();
        go(11);
        cyc();
        go(5);
        cyc();
        chk("t3_dn2", st, 4);
        chk("t3_dn2_idx", idx, 10);
        // kickback in DN2 at level 0
        go(7);
        chk("t3_lvl3", idx, 3);
        flick = 1'b1;
        cyc();
        flick = 1'b0;
        go(2);
        chk("t3_lvl0", idx, 0);
        chk("t3_st_dn2", st, 4);
        cyc();
        chk("t3_kick_st", st, 3);
        chk("t3_kick_led", led, 0);
        go(10);
        chk("t3_up2_led", led, 32'h03FF);
        cyc();
        chk("t3_redn2", st, 4);
        go(10);
        cyc();
        chk("t3_idle", st, 0);
        // flick during UP1 ignored
        pulse();
        go(3);
        flick = 1'b1;
        cyc();
        flick = 1'b0;
        go(12);
        chk("t4_up1_top", st, 1);
        chk("t4_up1_led", led, 32'hFFFF);
        cyc();
        go(11);
        chk("t4_no_kick_st", st, 2);
        chk("t4_no_kick_led", led, 32'h001F);
        cyc();
        chk("t4_up2", st, 3);
        reset = 1'b1;
        cyc();
        reset = 1'b0;
        chk("t4_rst_st", st, 0);
        // held flick starts one sequence only
        flick = 1'b1;
        go(20);
        chk("t4_held_st", st, 2);
        chk("t4_held_led", led, 32'h3FFF);
        flick = 1'b0;
        go(4);
        chk("t4_held_lvl10", idx, 10);
        cyc();
        chk("t4_held_pass", led, 32'h01FF);
        chk("t4_held_pass_st", st, 2);
        // reset mid-UP2
        go(4);
        cyc();
        go(2);
        chk("t5_up2", st, 3);
        chk("t5_lvl7", led, 32'h007F);
        reset = 1'b1;
        cyc();
        reset = 1'b0;
        chk("t5_rst_st", st, 0);
        chk("t5_rst_led", led, 0);
        chk("t5_rst_busy", busy, 0);
        chk("t5_rst_idx", idx, 0);
        pulse();
        chk("t5_restart", st, 1);
        cyc();
        chk("t5_restart_led", led, 32'h0001);
        // TICK_DIV=4 pacing
        flick4 = 1'b1;
        cyc();
        flick4 = 1'b0;
        chk("t6_up1", st4, 1);
        go(3);
        chk("t6_wait_idx", idx4, 0);
        chk("t6_wait_step", step4, 0);
        cyc();
        chk("t6_first_idx", idx4, 1);
        chk("t6_first_step", step4, 1);
        cyc();
        chk("t6_step_low", step4, 0);
        go(2);
        chk("t6_hold_idx", idx4, 1);
        cyc();
        chk("t6_second_idx", idx4, 2);
        chk("t6_second_led", led4, 32'h0003);
        chk("t6_second_step", step4, 1);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
